// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package    : mips_pkg
// Description: Shared definitions for the multi-cycle MIPS main control:
//              state enumeration, opcode constants, and the ALU-op,
//              ALU-B-source and PC-source encodings. Also provides a
//              helper that tells whether an opcode is implemented.
// Revision   : 1.0  initial release
// ============================================================================
package mips_pkg;

    // Controller states. Codes 13..15 are not produced by any transition.
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_EXEC_R   = 4'd7,
        ST_R_WB     = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_ADDI_EX  = 4'd11,
        ST_ADDI_WB  = 4'd12
    } state_e;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALU operation select
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // ALU B-operand source
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC next-value source
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // True for the opcodes this controller can sequence.
    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW)  || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)   || (op == OP_ADDI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_control_if.sv
`default_nettype none
// ============================================================================
// Interface  : mc_control_if
// Description: Control bus between the multi-cycle main control and the
//              datapath. The controller (master) reads the opcode, ALU zero
//              flag and memory ready, and drives every datapath
//              mux/enable/strobe plus a state debug view. The datapath
//              (slave) sees the opposite directions.
// Signals    : opcode[5:0], zero, mem_ready            datapath -> control
//              pc_en, iord, mem_rd, mem_wr, ir_wr, reg_wr, reg_dst,
//              mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[1:0],
//              pc_src[1:0], illegal_op, state_dbg[3:0]  control -> datapath
// Revision   : 1.0  initial release
// ============================================================================
interface mc_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       pc_en;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_wr;
    logic       reg_wr;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;
    logic [3:0] state_dbg;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, iord, mem_rd, mem_wr, ir_wr, reg_wr, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
               illegal_op, state_dbg
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, iord, mem_rd, mem_wr, ir_wr, reg_wr, reg_dst,
               mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
               illegal_op, state_dbg
    );
endinterface
`default_nettype wire

// File: rtl/mc_next_state.sv
`default_nettype none
// ============================================================================
// Module     : mc_next_state
// Description: Combinational next-state function of the multi-cycle MIPS
//              main control.
// Ports      : state      in   current state
//              opcode     in   IR[31:26]
//              mem_ready  in   memory access complete this cycle
//              next_state out  state to load at the next clock edge
// Revision   : 1.0  initial release
// ============================================================================
module mc_next_state
    import mips_pkg::*;
(
    input  state_e     state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output state_e     next_state
);

    always_comb begin
        next_state = ST_FETCH;
        case (state)
            ST_IDLE:     next_state = ST_FETCH;
            ST_FETCH:    next_state = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = ST_MEM_ADDR;
                    OP_RTYPE:     next_state = ST_EXEC_R;
                    OP_BEQ:       next_state = ST_BRANCH;
                    OP_J:         next_state = ST_JUMP;
                    OP_ADDI:      next_state = ST_ADDI_EX;
                    default:      next_state = ST_FETCH;
                endcase
            end
            // Only lw/sw reach MEM_ADDR, so anything but sw is the load path.
            ST_MEM_ADDR: next_state = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   next_state = mem_ready ? ST_MEM_WB : ST_MEM_RD;
            ST_MEM_WB:   next_state = ST_FETCH;
            ST_MEM_WR:   next_state = mem_ready ? ST_FETCH : ST_MEM_WR;
            ST_EXEC_R:   next_state = ST_R_WB;
            ST_R_WB:     next_state = ST_FETCH;
            ST_BRANCH:   next_state = ST_FETCH;
            ST_JUMP:     next_state = ST_FETCH;
            ST_ADDI_EX:  next_state = ST_ADDI_WB;
            ST_ADDI_WB:  next_state = ST_FETCH;
            // Unreachable codes recover through FETCH.
            default:     next_state = ST_FETCH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_control.sv
`default_nettype none
// ============================================================================
// Module     : mc_control
// Description: Multi-cycle MIPS main control FSM. Sequences
//              fetch/decode/execute/memory/writeback and drives the datapath
//              controls as Moore decodes of the state register; only pc_en
//              folds in the ALU zero flag, and FETCH's load strobes qualify
//              on mem_ready.
// Parameters : CNT_W  width of the optional performance counters
// Ports      : clk        in   system clock
//              rst_n      in   asynchronous active-low reset
//              bus        mc_control_if.master (opcode/zero/mem_ready in,
//                         datapath controls and state_dbg out)
//              cycle_cnt  out  non-IDLE cycle count   (MC_CONTROL_PERF_CNT_EN)
//              instr_cnt  out  completed instructions (MC_CONTROL_PERF_CNT_EN)
// Options    : define MC_CONTROL_PERF_CNT_EN to add the performance counters.
// Revision   : 1.0  initial release
// ============================================================================
module mc_control
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    mc_control_if.master        bus
`ifdef MC_CONTROL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    instr_cnt
`endif
);

    // A zero-width counter has no meaning; nothing is elaborated for it.
    if (CNT_W < 1) begin : g_cnt_w_invalid
    end

    state_e state_q;
    state_e state_d;

    mc_next_state u_next_state (
        .state      (state_q),
        .opcode     (bus.opcode),
        .mem_ready  (bus.mem_ready),
        .next_state (state_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    logic       pc_wr;
    logic       pc_wr_cond;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_wr;
    logic       reg_wr;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       illegal_op;

    always_comb begin
        pc_wr      = 1'b0;
        pc_wr_cond = 1'b0;
        iord       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALU_ADD;
        pc_src     = PCSRC_ALU;
        illegal_op = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_rd = 1'b1;
                // IR load and PC+4 happen only on the cycle memory delivers.
                if (bus.mem_ready) begin
                    ir_wr     = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    pc_wr     = 1'b1;
                end
            end
            ST_DECODE: begin
                // Branch target precomputed while the register file reads.
                alu_src_b  = SRCB_IMM_SH2;
                illegal_op = !is_legal_op(bus.opcode);
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEM_RD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
            end
            ST_MEM_WB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            ST_R_WB: begin
                reg_wr  = 1'b1;
                reg_dst = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_SUB;
                pc_src     = PCSRC_ALUOUT;
                pc_wr_cond = 1'b1;
            end
            ST_JUMP: begin
                pc_src = PCSRC_JUMP;
                pc_wr  = 1'b1;
            end
            ST_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ST_ADDI_WB: begin
                reg_wr = 1'b1;
            end
            default: begin
                // IDLE and unreachable codes keep every output low.
            end
        endcase
    end

    assign bus.pc_en      = pc_wr | (pc_wr_cond & bus.zero);
    assign bus.iord       = iord;
    assign bus.mem_rd     = mem_rd;
    assign bus.mem_wr     = mem_wr;
    assign bus.ir_wr      = ir_wr;
    assign bus.reg_wr     = reg_wr;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_op     = alu_op;
    assign bus.pc_src     = pc_src;
    assign bus.illegal_op = illegal_op;
    assign bus.state_dbg  = state_q;

`ifdef MC_CONTROL_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Performance counters (wrap naturally at 2^CNT_W)
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q;
    logic [CNT_W-1:0] instr_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (state_q != ST_IDLE) begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
        // An instruction retires when FETCH is re-entered; a FETCH stall
        // is not a re-entry, and the IDLE->FETCH start-up is not a retire.
        if (state_q != ST_IDLE && state_q != ST_FETCH && state_d == ST_FETCH) begin
            instr_cnt_d = instr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule
`default_nettype wire
